// File: rtl/accel_pkg.sv
// accel_pkg: opcodes, instruction fields, packet types and loader states
package accel_pkg;
   localparam logic [5:0] OP_NOP    = 6'd0;
   localparam logic [5:0] OP_MATMUL = 6'd1;
   localparam logic [5:0] OP_VADD   = 6'd2;
   localparam logic [5:0] OP_MOVE   = 6'd3;
   localparam logic [5:0] OP_RELU   = 6'd4;
   localparam logic [5:0] OP_HALT   = 6'd10;
   localparam int OPC_HI = 23, OPC_LO = 18;
   localparam int OP1_HI = 17, OP1_LO = 13;
   localparam int OP2_HI = 12, OP2_LO = 8;
   localparam int OP3_HI = 7,  OP3_LO = 3;
   localparam int OP4_HI = 2,  OP4_LO = 0;
   typedef enum logic [1:0] {PKT_INSTR = 2'd0, PKT_DATA = 2'd1, PKT_RUN = 2'd2, PKT_RSVD = 2'd3} pkt_t;
   typedef enum logic [2:0] {S_IDLE, S_PAYLOAD, S_COMMIT, S_RUN, S_WAIT_DONE} loader_state_t;
   // An instruction is legal when its opcode is known and the top byte is clear
   function automatic logic op_ok(input logic [31:0] w);
      logic [5:0] op;
      op = w[OPC_HI:OPC_LO];
      return w[31:24] == 8'd0 && (op == OP_NOP || op == OP_MATMUL || op == OP_VADD ||
                                  op == OP_MOVE || op == OP_RELU || op == OP_HALT);
   endfunction
endpackage

// File: rtl/prog_loader_assembler.sv
// prog_loader_assembler: little-endian byte-lane assembly of payload words
module prog_loader_assembler (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        shift,
   input  logic [1:0]  len,
   input  logic [7:0]  data,
   output logic [31:0] word_nxt,
   output logic        last
);
   logic [31:0] word;
   logic [1:0]  cnt;
   assign last = shift && cnt == len;
   // Word as it will look once the incoming byte lands in its lane
   always_comb begin
      word_nxt = word;
      word_nxt[{cnt, 3'b000} +: 8] = data;
   end
   // Lane counter and shift register, cleared at each new header
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         word <= '0;
         cnt  <= '0;
      end else if (clr) begin
         word <= '0;
         cnt  <= '0;
      end else if (shift) begin
         word <= word_nxt;
         cnt  <= cnt + 2'd1;
      end
endmodule

// File: rtl/prog_loader.sv
// prog_loader: packet parser writing accelerator imem/dmem and launching runs; LOADER_OPCODE_CHECK_EN enables instruction legality checking
module prog_loader import accel_pkg::*; #(
   parameter int NUM_SIZE         = 16,
   parameter int NUM_INSTRUCTIONS = 16,
   parameter int WORDS_IN_MEMORY  = 32
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [7:0]                            in_data,
   output logic                                  imem_we,
   output logic [$clog2(NUM_INSTRUCTIONS)-1:0]   imem_addr,
   output logic [31:0]                           imem_wdata,
   output logic                                  dmem_we,
   output logic [$clog2(WORDS_IN_MEMORY)-1:0]    dmem_addr,
   output logic [NUM_SIZE-1:0]                   dmem_wdata,
   output logic                                  start,
   input  logic                                  accel_done,
   output logic                                  busy,
   output logic                                  err,
   output logic [$clog2(NUM_INSTRUCTIONS):0]     instr_count
);
   localparam int IAW = $clog2(NUM_INSTRUCTIONS);
   localparam int DAW = $clog2(WORDS_IN_MEMORY);
   localparam int AW  = IAW > DAW ? IAW : DAW;
   localparam int CW  = IAW + 1;
   loader_state_t state;
   pkt_t          typ;
   logic [AW-1:0] addr;
   logic          drop;
   logic          xfer, in_range, last, valid_op;
   logic [31:0]   word_nxt;
   assign xfer     = in_valid && in_ready;
   assign in_range = in_data[6] ? 32'(in_data[5:0]) < WORDS_IN_MEMORY
                                : 32'(in_data[5:0]) < NUM_INSTRUCTIONS;
`ifdef LOADER_OPCODE_CHECK_EN
   assign valid_op = op_ok(word_nxt);
`else
   assign valid_op = 1'b1;
`endif
   prog_loader_assembler u_asm (
      .clk      (clk),
      .rst      (rst),
      .clr      (xfer && state == S_IDLE),
      .shift    (xfer && state == S_PAYLOAD),
      .len      (typ == PKT_DATA ? 2'd1 : 2'd3),
      .data     (in_data),
      .word_nxt (word_nxt),
      .last     (last)
   );
   // Packet FSM; every output is registered and set on the transition into its state
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state       <= S_IDLE;
         typ         <= PKT_INSTR;
         addr        <= '0;
         drop        <= 1'b0;
         in_ready    <= 1'b1;
         busy        <= 1'b0;
         imem_we     <= 1'b0;
         imem_addr   <= '0;
         imem_wdata  <= '0;
         dmem_we     <= 1'b0;
         dmem_addr   <= '0;
         dmem_wdata  <= '0;
         start       <= 1'b0;
         err         <= 1'b0;
         instr_count <= '0;
      end else begin
         imem_we <= 1'b0;
         dmem_we <= 1'b0;
         start   <= 1'b0;
         case (state)
            S_IDLE: if (xfer) begin
               typ  <= pkt_t'(in_data[7:6]);
               addr <= AW'(in_data[5:0]);
               case (pkt_t'(in_data[7:6]))
                  PKT_INSTR, PKT_DATA: begin
                     state <= S_PAYLOAD;
                     busy  <= 1'b1;
                     drop  <= !in_range;
                     if (!in_range) err <= 1'b1;
                  end
                  PKT_RUN: begin
                     state    <= S_RUN;
                     busy     <= 1'b1;
                     in_ready <= 1'b0;
                     start    <= 1'b1;
                  end
                  default: err <= 1'b1;
               endcase
            end
            S_PAYLOAD: if (last) begin
               if (drop) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else begin
                  state    <= S_COMMIT;
                  in_ready <= 1'b0;
                  if (typ == PKT_DATA) begin
                     dmem_we    <= 1'b1;
                     dmem_addr  <= addr[DAW-1:0];
                     dmem_wdata <= NUM_SIZE'(word_nxt[15:0]);
                  end else if (valid_op) begin
                     imem_we    <= 1'b1;
                     imem_addr  <= addr[IAW-1:0];
                     imem_wdata <= word_nxt;
                     if (instr_count != CW'(NUM_INSTRUCTIONS)) instr_count <= instr_count + 1'b1;
                  end else err <= 1'b1;
               end
            end
            S_COMMIT: begin
               state    <= S_IDLE;
               in_ready <= 1'b1;
               busy     <= 1'b0;
            end
            S_RUN: state <= S_WAIT_DONE;
            S_WAIT_DONE: if (accel_done) begin
               state    <= S_IDLE;
               in_ready <= 1'b1;
               busy     <= 1'b0;
            end
            default: begin
               state    <= S_IDLE;
               in_ready <= 1'b1;
               busy     <= 1'b0;
            end
         endcase
      end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized packet stimulus with a queue scoreboard and a packet-level reference model
module tb_prog_loader;
   localparam int NS = 16, NI = 16, NW = 32;
   logic        clk = 0, rst = 1, in_valid = 0, accel_done = 0;
   logic [7:0]  in_data = 0;
   logic        in_ready, imem_we, dmem_we, start, busy, err;
   logic [3:0]  imem_addr;
   logic [4:0]  dmem_addr;
   logic [31:0] imem_wdata;
   logic [15:0] dmem_wdata;
   logic [4:0]  instr_count;
   prog_loader #(.NUM_SIZE(NS), .NUM_INSTRUCTIONS(NI), .WORDS_IN_MEMORY(NW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .start(start), .accel_done(accel_done), .busy(busy), .err(err), .instr_count(instr_count)
   );
   always #5 clk = ~clk;
   typedef struct packed {logic [1:0] kind; logic [5:0] addr; logic [31:0] wdata; logic [4:0] cnt;} exp_t;
   exp_t exp_q[$];
   int   checks = 0, passes = 0;
   bit   m_err = 0;
   int   m_cnt = 0;
   exp_t mon_e;
   logic [1:0] mon_k;
   logic prev_start = 0;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act === want) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
   endtask
   function automatic bit op_allowed(input logic [31:0] w);
`ifdef LOADER_OPCODE_CHECK_EN
      return w[31:24] == 8'd0 && (w[23:18] inside {6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd10});
`else
      return 1'b1;
`endif
   endfunction
   function automatic int gap(input int gm);
      if (gm == 2) return 1;
      if (gm == 1 && $urandom_range(0, 3) == 0) return int'($urandom_range(1, 2));
      return 0;
   endfunction
   task automatic send_byte(input logic [7:0] b, input int g);
      int n = 0;
      repeat (g) @(negedge clk);
      @(negedge clk);
      in_valid = 1;
      in_data  = b;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         checks++;
         $display("FAIL handshake: in_ready stayed 0, expected 1");
      end
      @(posedge clk);
      #1 in_valid = 0;
   endtask
   task automatic send_instr(input logic [5:0] a, input logic [31:0] w, input int gm);
      bit wr = 0;
      if (a >= NI || !op_allowed(w)) m_err = 1;
      else begin
         wr = 1;
         if (m_cnt < NI) m_cnt++;
         exp_q.push_back('{2'd0, a, w, 5'(m_cnt)});
      end
      send_byte({2'b00, a}, gap(gm));
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap(gm));
      @(negedge clk);
      chk("imem_latency", imem_we, wr);
      chk("err_instr", err, m_err);
   endtask
   task automatic send_data(input logic [5:0] a, input logic [15:0] v, input int gm);
      bit wr = 0;
      if (a >= NW) m_err = 1;
      else begin
         wr = 1;
         exp_q.push_back('{2'd1, a, {16'd0, v}, 5'(m_cnt)});
      end
      send_byte({2'b01, a}, gap(gm));
      send_byte(v[7:0], gap(gm));
      send_byte(v[15:8], gap(gm));
      @(negedge clk);
      chk("dmem_latency", dmem_we, wr);
      chk("err_data", err, m_err);
   endtask
   task automatic send_run(input int dly, input bit early);
      exp_q.push_back('{2'd2, 6'd0, 32'd0, 5'(m_cnt)});
      accel_done = early;
      send_byte(8'h80, 0);
      @(negedge clk);
      chk("start_pulse", start, 1);
      if (early) begin
         @(negedge clk);
         chk("wait_one_cycle", busy, 1);
         @(negedge clk);
         chk("early_done_idle", busy, 0);
      end else begin
         repeat (dly) @(negedge clk);
         chk("busy_wait", busy, 1);
         chk("ready_wait", in_ready, 0);
         accel_done = 1;
         @(negedge clk);
         chk("idle_after_done", busy, 0);
         chk("ready_after_done", in_ready, 1);
      end
      accel_done = 0;
   endtask
   task automatic send_rsvd(input int gm);
      m_err = 1;
      send_byte({2'b11, 6'($urandom_range(0, 63))}, gap(gm));
      @(negedge clk);
      chk("err_rsvd", err, 1);
      chk("busy_rsvd", busy, 0);
   endtask
   task automatic check_reset();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      chk("rst_count", instr_count, 0);
      chk("rst_imem_we", imem_we, 0);
      chk("rst_imem_addr", imem_addr, 0);
      chk("rst_imem_wdata", imem_wdata, 0);
      chk("rst_dmem_we", dmem_we, 0);
      chk("rst_dmem_addr", dmem_addr, 0);
      chk("rst_dmem_wdata", dmem_wdata, 0);
      chk("rst_start", start, 0);
   endtask
   always @(negedge clk) begin
      if (rst) prev_start = 0;
      else begin
         if (imem_we) chk("strobe_exclusive", dmem_we, 0);
         if (start) chk("start_width", prev_start, 0);
         if (imem_we || dmem_we || start) begin
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL scoreboard: event imem_we=%0b dmem_we=%0b start=%0b, expected none", imem_we, dmem_we, start);
            end else begin
               mon_e = exp_q.pop_front();
               mon_k = start ? 2'd2 : dmem_we ? 2'd1 : 2'd0;
               chk("event_kind", mon_k, mon_e.kind);
               chk("commit_in_ready", in_ready, 0);
               chk("commit_busy", busy, 1);
               if (mon_k == 2'd0) begin
                  chk("imem_addr", imem_addr, mon_e.addr);
                  chk("imem_wdata", imem_wdata, mon_e.wdata);
                  chk("instr_count", instr_count, mon_e.cnt);
               end else if (mon_k == 2'd1) begin
                  chk("dmem_addr", dmem_addr, mon_e.addr);
                  chk("dmem_wdata", dmem_wdata, mon_e.wdata);
               end
            end
         end
         prev_start = start;
      end
   end
   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation still running, expected completion");
      $fatal(1);
   end
   initial begin
      logic [5:0]  ops [6];
      logic [31:0] w;
      int          r;
      ops = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd10};
      repeat (2) @(negedge clk);
      check_reset();
      rst = 0;
      send_instr(6'd3, 32'h0004_2000, 0);
      send_data(6'd5, 16'h1234, 0);
      send_run(10, 0);
      send_instr(6'd20, 32'hDEAD_BEEF, 0);
      send_data(6'd7, 16'hA55A, 0);
      send_data(6'd9, 16'hBEEF, 2);
      send_instr(6'd1, 32'h001C_0000, 0);
      send_instr(6'd2, 32'h0028_0000, 0);
      send_run(3, 1);
      send_rsvd(0);
      send_byte(8'h02, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      @(negedge clk);
      rst = 1;
      #1 check_reset();
      m_err = 0;
      m_cnt = 0;
      exp_q.delete();
      @(negedge clk);
      rst = 0;
      send_data(6'd31, 16'h00FF, 0);
      send_data(6'd32, 16'h1111, 0);
      for (int k = 0; k < 150; k++) begin
         r = int'($urandom_range(0, 9));
         if (r < 4) begin
            w = $urandom();
            if ($urandom_range(0, 1) == 1) w = {8'd0, ops[$urandom_range(0, 5)], w[17:0]};
            send_instr(6'($urandom_range(0, 19)), w, 1);
         end else if (r < 7) send_data(6'($urandom_range(0, 35)), 16'($urandom()), 1);
         else if (r < 9) send_run(int'($urandom_range(1, 6)), $urandom_range(0, 2) == 0);
         else send_rsvd(1);
      end
      repeat (3) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);
      chk("final_count", instr_count, m_cnt);
      chk("final_err", err, m_err);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
